ctrl_seq: RTL and testbench

Parametrised, registered successor to the team's flat combinational control decoder. Accepts opcodes over a valid/ready handshake and expands each into a sequence of 1..MAX_PH registered control words, one per phase. Supports output backpressure, abort, illegal-opcode flagging and back-to-back issue without bubbles. Sits between the instruction/command source and the datapath it steers.

---
 rtl/ctrl_seq_pkg.sv | 23 ++
 rtl/ctrl_seq_phase_cnt.sv | 46 ++++
 rtl/ctrl_seq.sv | 123 ++++++++++++
 tb/tb_ctrl_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared types, control-word field offsets and opcode helpers for ctrl_seq.
package ctrl_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int unsigned CW_FIRST  = 0;
  localparam int unsigned CW_LAST   = 1;
  localparam int unsigned CW_OP_LSB = 2;

  localparam int unsigned OP_W_MAX  = 32;
  localparam int unsigned DONE_W    = 16;

  // All-ones opcode of the live width is reserved as illegal.
  function automatic logic is_illegal(input logic [OP_W_MAX-1:0] op, input int unsigned op_w);
    logic [OP_W_MAX-1:0] mask;
    mask = {OP_W_MAX{1'b1}} >> (OP_W_MAX - op_w);
    return (op & mask) == mask;
  endfunction

endpackage

// File: rtl/ctrl_seq_phase_cnt.sv
// Phase counter for ctrl_seq: load/increment/clear plus last-phase compare.
module ctrl_seq_phase_cnt #(
  parameter int unsigned PH_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic            clr_i,
  input  logic [PH_W-1:0] len_i,
  output logic [PH_W-1:0] phase_d_o,
  output logic [PH_W-1:0] len_d_o,
  output logic            last_o
);

  logic [PH_W-1:0] phase_q, phase_d;
  logic [PH_W-1:0] len_q, len_d;

  always_comb begin
    phase_d = phase_q;
    len_d   = len_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (load_i) begin
      phase_d = '0;
      len_d   = len_i;
    end else if (inc_i) begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      len_q   <= '0;
    end else begin
      phase_q <= phase_d;
      len_q   <= len_d;
    end
  end

  assign phase_d_o = phase_d;
  assign len_d_o   = len_d;
  assign last_o    = (phase_q == len_q);

endmodule

// File: rtl/ctrl_seq.sv
// Opcode sequencer: expands each accepted opcode into 1..MAX_PH registered
// control words with valid/ready on both sides, abort and illegal-op flagging.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter  int unsigned OP_W   = 5,
  parameter  int unsigned MAX_PH = 4,
  localparam int unsigned PH_W   = $clog2(MAX_PH),
  localparam int unsigned CW_W   = 2 + OP_W + PH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [PH_W-1:0]   in_len,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [DONE_W-1:0] done_cnt
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [PH_W-1:0]   phase_d, len_d;
  logic [CW_W-1:0]   cw_d;
  logic              last;
  logic              legal, accept, load, inc, clr, done, err_set;

  logic              out_valid_q, out_last_q, busy_q, err_q;
  logic [CW_W-1:0]   out_cw_q;
  logic [DONE_W-1:0] done_cnt_q;

  ctrl_seq_phase_cnt #(.PH_W(PH_W)) u_phase_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (load),
    .inc_i     (inc),
    .clr_i     (clr),
    .len_i     (in_len),
    .phase_d_o (phase_d),
    .len_d_o   (len_d),
    .last_o    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = EXEC;
      EXEC: if (done) state_d = load ? EXEC : IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Handshake and strobes; a final-phase transfer still counts when aborted.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    inc      = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      EXEC: begin
        in_ready = last & out_ready;
        done     = last & out_ready;
        inc      = ~last & out_ready & ~abort;
      end
    endcase
    if (rst || abort) in_ready = 1'b0;
    legal   = ~is_illegal(OP_W_MAX'(in_op), OP_W);
    accept  = in_valid & in_ready;
    load    = accept & legal;
    err_set = accept & ~legal;
    clr     = abort | (done & ~load);
  end

  always_comb begin
    op_d = load ? in_op : op_q;
    cw_d = '0;
    if (state_d == EXEC) begin
      cw_d[CW_FIRST]                = (phase_d == '0);
      cw_d[CW_LAST]                 = (phase_d == len_d);
      cw_d[CW_OP_LSB +: OP_W]       = op_d;
      cw_d[CW_OP_LSB + OP_W +: PH_W] = phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_cw_q    <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      op_q        <= op_d;
      out_valid_q <= (state_d == EXEC);
      out_cw_q    <= cw_d;
      out_last_q  <= cw_d[CW_LAST];
      busy_q      <= (state_d == EXEC);
      if (err_set) err_q <= 1'b1;
      if (done)    done_cnt_q <= done_cnt_q + DONE_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_cw    = out_cw_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: scenario tasks plus a word scoreboard.
module tb_ctrl_seq;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned MAX_PH = 4;
  localparam int unsigned PH_W   = 2;
  localparam int unsigned CW_W   = 2 + OP_W + PH_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [PH_W-1:0] in_len;
  logic            abort;
  logic            out_valid;
  logic            out_ready;
  logic [CW_W-1:0] out_cw;
  logic            out_last;
  logic            busy;
  logic            err;
  logic [15:0]     done_cnt;

  int              checks = 0;
  int              errors = 0;
  logic [15:0]     exp_done = '0;
  logic [CW_W-1:0] exp_q[$];
  logic [CW_W-1:0] sb_exp;
  bit              sb_en = 1'b1;

  ctrl_seq #(.OP_W(OP_W), .MAX_PH(MAX_PH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_len    (in_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cw    (out_cw),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW_W-1:0] mk_cw(input logic [OP_W-1:0] op, input logic [PH_W-1:0] len, input int p);
    logic [PH_W-1:0] ph;
    ph = PH_W'(p);
    return {ph, op, (ph == len), (p == 0)};
  endfunction

  // Every transferred word must match the head of the expected queue.
  always @(negedge clk) begin
    if (sb_en && !rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got cw=%h, no word expected", out_cw);
      end else begin
        sb_exp = exp_q.pop_front();
        if (out_cw !== sb_exp || out_last !== sb_exp[1]) begin
          errors++;
          $display("FAIL sb_word: got cw=%h last=%b, expected cw=%h last=%b", out_cw, out_last, sb_exp, sb_exp[1]);
        end
      end
    end
  end

  task automatic offer(input logic [OP_W-1:0] op, input logic [PH_W-1:0] len, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_len   = len;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL offer_ready: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end else if (op != 5'h1F) begin
      for (int p = 0; p <= int'(len); p++) exp_q.push_back(mk_cw(op, len, p));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_len = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_hold: got %b expected 0", in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got valid/last/busy/err=%b expected 0000", {out_valid, out_last, busy, err});
    end
    checks++;
    if (out_cw !== '0) begin errors++; $display("FAIL reset_cw: got %h expected 0", out_cw); end
    checks++;
    if (done_cnt !== 16'h0) begin errors++; $display("FAIL reset_done: got %h expected 0", done_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int w;
    @(posedge clk); #1 out_ready = 1'b1;
    offer(5'h03, 2'd2, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL basic_valid: cycle %0d got valid=%b busy=%b expected 1/1", i, out_valid, busy);
      end
    end
    @(negedge clk);
    exp_done = exp_done + 16'd1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got valid=%b busy=%b expected 0/0", out_valid, busy);
    end
    checks++;
    if (done_cnt !== exp_done) begin errors++; $display("FAIL basic_done: got %h expected %h", done_cnt, exp_done); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: %0d words left, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int w;
    @(posedge clk); #1 out_ready = 1'b1;
    offer(5'h01, 2'd0, w);
    offer(5'h02, 2'd1, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL b2b_ready_last: waited %0d cycles expected 0", w); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_mid: got %b expected 1", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_last !== 1'b1) begin
      errors++; $display("FAIL b2b_last: got valid/ready/last=%b%b%b expected 111", out_valid, in_ready, out_last);
    end
    @(negedge clk);
    exp_done = exp_done + 16'd2;
    checks++;
    if (out_valid !== 1'b0 || done_cnt !== exp_done) begin
      errors++; $display("FAIL b2b_end: got valid=%b done=%h expected 0/%h", out_valid, done_cnt, exp_done);
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic [CW_W-1:0] hold;
    @(posedge clk); #1 out_ready = 1'b1;
    offer(5'h04, 2'd3, w);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    hold = mk_cw(5'h04, 2'd3, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_cw !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: cycle %0d got cw=%h valid=%b ready=%b expected %h/1/0", i, out_cw, out_valid, in_ready, hold);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_cw !== mk_cw(5'h04, 2'd3, 2)) begin
      errors++; $display("FAIL bp_resume: got %h expected %h", out_cw, mk_cw(5'h04, 2'd3, 2));
    end
    @(negedge clk);
    @(negedge clk);
    exp_done = exp_done + 16'd1;
    checks++;
    if (out_valid !== 1'b0 || done_cnt !== exp_done) begin
      errors++; $display("FAIL bp_end: got valid=%b done=%h expected 0/%h", out_valid, done_cnt, exp_done);
    end
  endtask

  task automatic test_illegal();
    int w;
    @(posedge clk); #1 out_ready = 1'b1;
    offer(5'h1F, 2'd0, w);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || done_cnt !== exp_done) begin
      errors++; $display("FAIL illegal_idle: got valid=%b busy=%b err=%b done=%h expected 0/0/1/%h", out_valid, busy, err, done_cnt, exp_done);
    end
    @(posedge clk); #1;
    offer(5'h06, 2'd1, w);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_done = exp_done + 16'd1;
    checks++;
    if (err !== 1'b1 || done_cnt !== exp_done) begin
      errors++; $display("FAIL illegal_sticky: got err=%b done=%h expected 1/%h", err, done_cnt, exp_done);
    end
    @(posedge clk); #1;
    offer(5'h07, 2'd0, w);
    offer(5'h1F, 2'd0, w);
    in_valid = 1'b0;
    @(negedge clk);
    exp_done = exp_done + 16'd1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== exp_done) begin
      errors++; $display("FAIL illegal_handover: got valid=%b busy=%b done=%h expected 0/0/%h", out_valid, busy, done_cnt, exp_done);
    end
  endtask

  task automatic test_abort();
    int w;
    @(posedge clk); #1 out_ready = 1'b1;
    offer(5'h08, 2'd3, w);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_blocks: got in_ready=%b expected 0", in_ready); end
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== exp_done || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_mid: got valid=%b busy=%b done=%h ready=%b expected 0/0/%h/1", out_valid, busy, done_cnt, in_ready, exp_done);
    end
    @(posedge clk); #1;
    offer(5'h09, 2'd1, w);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    exp_done = exp_done + 16'd1;
    checks++;
    if (out_valid !== 1'b0 || done_cnt !== exp_done || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_last: got valid=%b done=%h left=%0d expected 0/%h/0", out_valid, done_cnt, exp_q.size(), exp_done);
    end
    @(posedge clk); #1 abort = 1'b1; in_valid = 1'b1; in_op = 5'h0A; in_len = 2'd0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle_noop: got valid=%b busy=%b expected 0/0", out_valid, busy);
    end
  endtask

  task automatic test_wrap();
    int n;
    sb_en = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1; in_op = 5'h00; in_len = 2'd0;
    n = 65536 - int'(exp_done);
    in_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt !== 16'hFFFF || out_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_max: got done=%h valid=%b expected ffff/1", done_cnt, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 16'h0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_zero: got done=%h valid=%b expected 0000/0", done_cnt, out_valid);
    end
    exp_done = '0;
    sb_en = 1'b1;
  endtask

  task automatic test_rst_mid();
    int w;
    @(posedge clk); #1 out_ready = 1'b1;
    offer(5'h0B, 2'd0, w);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    exp_done = exp_done + 16'd1;
    offer(5'h0A, 2'd3, w);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || done_cnt !== exp_done) begin
      errors++; $display("FAIL rst_mid_hold: got ready=%b done=%h expected 0/%h", in_ready, done_cnt, exp_done);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_done = '0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, err} !== 4'b0000 || out_cw !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got valid/last/busy/err=%b cw=%h expected 0000/0", {out_valid, out_last, busy, err}, out_cw);
    end
    checks++;
    if (done_cnt !== exp_done || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_state: got done=%h ready=%b expected 0/1", done_cnt, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_abort();
    test_wrap();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
